// File: rtl/load_align_unit_pkg.sv
// Shared load definitions: size/sign mode encodings, FSM states and the access size decode.
package load_align_unit_pkg;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;
  localparam logic [1:0] LD_D = 2'b11;
  localparam int LD_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A dword request on a 4-byte datapath collapses to a word.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz, input int nb);
    logic [3:0] n;
    case (sz)
      LD_B:    n = 4'd1;
      LD_H:    n = 4'd2;
      LD_W:    n = 4'd4;
      default: n = (nb == 8) ? 4'd8 : 4'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_align_unit_lane_extract.sv
// Combinational lane extractor: {hi, lo} little-endian pair, byte offset and mode to an extended XLEN value.
module load_align_unit_lane_extract
  import load_align_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          pair,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [2:0]                 mode,
  output logic [XLEN-1:0]            result
);

  localparam int NB = XLEN / 8;

  logic [3:0]      sz_bytes;
  logic [XLEN-1:0] window;
  logic            sign_bit;
  logic            ext_bit;

  assign sz_bytes = size_bytes(mode[1:0], NB);
  assign window   = XLEN'(pair >> {offset, 3'b000});

  always_comb begin
    case (sz_bytes)
      4'd1:    sign_bit = window[7];
      4'd2:    sign_bit = window[15];
      4'd4:    sign_bit = window[31];
      default: sign_bit = window[XLEN-1];
    endcase
  end

  assign ext_bit = ~mode[LD_UNSIGNED_BIT] & sign_bit;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign result[gi*8 +: 8] = (4'(gi) < sz_bytes) ? window[gi*8 +: 8] : {8{ext_bit}};
    end
  endgenerate

endmodule

// File: rtl/load_align_unit.sv
// Memory-stage load formatter with two-beat merge of word-crossing loads.
// Define LOAD_MISALIGN_TRAP_EN to fault crossing loads instead of splitting them.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_addr,
  input  logic [2:0]      in_mode,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_split,
  output logic            out_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  state_t            state_reg;
  logic [AW-1:0]     addr_reg;
  logic [2:0]        mode_reg;
  logic [OFFW-1:0]   offset_reg;
  logic [XLEN-1:0]   lo_buf_reg;
  logic [XLEN-1:0]   out_data_reg;
  logic              out_valid_reg;
  logic              out_split_reg;

  logic [AW-1:0]     in_aligned;
  logic [3:0]        sz_bytes;
  logic              crossing;
  logic              second_beat;
  logic [2*XLEN-1:0] pair;
  logic [XLEN-1:0]   ext_result;

  assign in_aligned = {in_addr[AW-1:OFFW], {OFFW{1'b0}}};
  assign sz_bytes   = size_bytes(mode_reg[1:0], NB);
  assign crossing   = (5'(offset_reg) + 5'(sz_bytes)) > 5'(NB);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign second_beat = 1'b0;
`else
  assign second_beat = crossing;
`endif

  // In BEAT0 the low word is still on the bus; in BEAT1 it comes from lo_buf.
  assign pair = (state_reg == BEAT1) ? {mem_rdata, lo_buf_reg} : {{XLEN{1'b0}}, mem_rdata};

  load_align_unit_lane_extract #(.XLEN(XLEN)) u_extract (
    .pair   (pair),
    .offset (offset_reg),
    .mode   (mode_reg),
    .result (ext_result)
  );

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign mem_req   = !rst && (((state_reg == IDLE) && in_valid) ||
                              ((state_reg == BEAT0) && second_beat));
  assign mem_addr  = (state_reg == IDLE) ? in_aligned : addr_reg + AW'(NB);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_split = out_split_reg;

`ifdef LOAD_MISALIGN_TRAP_EN
  logic out_fault_reg;
  assign out_fault = out_fault_reg;
`else
  assign out_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      mode_reg      <= '0;
      offset_reg    <= '0;
      lo_buf_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_split_reg <= 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
      out_fault_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            addr_reg   <= in_aligned;
            mode_reg   <= in_mode;
            offset_reg <= in_addr[OFFW-1:0];
            state_reg  <= BEAT0;
          end
        end
        BEAT0: begin
          lo_buf_reg <= mem_rdata;
          if (second_beat) begin
            state_reg <= BEAT1;
          end else begin
            out_valid_reg <= 1'b1;
            out_split_reg <= 1'b0;
            state_reg     <= DONE;
`ifdef LOAD_MISALIGN_TRAP_EN
            out_fault_reg <= crossing;
            out_data_reg  <= crossing ? '0 : ext_result;
`else
            out_data_reg  <= ext_result;
`endif
          end
        end
        BEAT1: begin
          out_data_reg  <= ext_result;
          out_split_reg <= 1'b1;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Memory-stage load formatter. It is the next generation of the combinational LB/LH/LBU/LHU extender.
- Parametrised in XLEN (32 or 64), with byte/half/word/dword modes.
- Performs byte-lane extraction from the address offset.
- Misaligned loads that cross a data-word boundary are split into two memory beats and merged.
- Sits between the execute/memory pipeline register and writeback. Valid/ready on both sides; drives a 1-cycle-latency synchronous data memory read port.

Parameters:
- XLEN, 32, data width in bits; legal values 32, 64.
- AW, 32, byte-address width.
- NB, XLEN/8, localparam, bytes per memory word.
- OFFW, $clog2(NB), localparam, width of the in-word byte offset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  load request valid.
- in_ready  out  1  unit can accept a request.
- in_addr  in  AW  byte address of the load.
- in_mode  in  3  [2]=unsigned, [1:0]=size: 00 byte, 01 half, 10 word, 11 dword.
- mem_req  out  1  memory read strobe.
- mem_addr  out  AW  NB-aligned word address.
- mem_rdata  in  XLEN  read data, valid exactly one cycle after mem_req.
- out_valid  out  1  formatted result valid.
- out_ready  in  1  writeback accepts result.
- out_data  out  XLEN  extended load value.
- out_split  out  1  result used two beats.
- out_fault  out  1  misaligned fault; tied 0 unless the optional feature is compiled in.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, in_ready=0 while rst is high, mem_req=0, out_valid=0, out_data=0, out_split=0, out_fault=0.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - in_ready=1 and mem_req=in_valid, with mem_addr = in_addr with its low OFFW bits cleared.
  - On in_valid, latch addr, mode and offset=in_addr[OFFW-1:0], then go to BEAT0.
- BEAT0:
  - Capture mem_rdata into lo_buf.
  - Access crosses a word boundary when offset + size_bytes > NB.
  - If crossing: mem_req=1, mem_addr = aligned + NB (wraps modulo 2^AW), go to BEAT1.
  - Otherwise compute the result with hi=0 and go to DONE.
- BEAT1: capture mem_rdata as hi, compute the result, set out_split=1, go to DONE.
- DONE:
  - out_valid=1, with out_data, out_split and out_fault registered and stable while out_ready=0.
  - On out_ready, go to IDLE.
  - No new request is accepted in DONE (in_ready=0).
- Result computation:
  - Shift {hi, lo} (2*XLEN bits, little-endian) right by offset*8.
  - Keep the low size_bytes bytes.
  - Sign-extend from the top kept bit if in_mode[2]=0, else zero-extend.
- Dword mode with XLEN=32 is treated as word.
- Unsigned word when XLEN=32 equals signed word.
- Latency: aligned request gives out_valid 2 cycles after acceptance; split request gives 3.
- in_ready is 0 from acceptance until the DONE handshake completes.
- Reset mid-operation returns to IDLE immediately. mem_rdata from an aborted beat is ignored and no result is emitted.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined: a crossing access does not issue a second beat. BEAT0 goes to DONE with out_data=0, out_fault=1, out_split=0.
- Undefined: crossing accesses are split as above, and out_fault is constant 0.

Decomposition:
- Shared package/header load_defs:
  - mode encodings: LD_B, LD_H, LD_W, LD_D and the unsigned bit index;
  - FSM state constants;
  - size_bytes decode function.
- Sub-module: load_lane_extract, purely combinational ({hi, lo}, offset, mode -> extended XLEN result). It is reused by the store path later.

Test Plan:
- All tests use XLEN=32, mem[0x100]=0xDEADBEEF, mem[0x104]=0x11223380.
- LB @0x103 -> out_data=0xFFFFFFDE, out_split=0, out_valid 2 cycles after accept. LBU @0x103 -> 0x000000DE.
- LH @0x102 -> 0xFFFFDEAD. LHU @0x100 -> 0x0000BEEF. LW @0x100 -> 0xDEADBEEF.
- LW @0x103 -> mem_addr 0x100 then 0x104 on consecutive cycles, out_data=0x223380DE, out_split=1, valid at cycle 3. With LOAD_MISALIGN_TRAP_EN: single mem_req, out_fault=1, out_data=0.
- LH @0x103 -> 0xFFFF80DE. LHU @0x103 -> 0x000080DE, out_split=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0, no mem_req. Release -> IDLE next cycle.
- Assert rst during BEAT1 -> same cycle mem_req=0 and out_valid=0. After release, in_ready=1 and no stale result appears.
